// File: rtl/vga_pkg.sv
// Shared VGA-side types and constants: screen codes for the screen mux and
// the PS/2 make codes used as default game-control keys.
package vga_pkg;

    typedef enum logic [2:0] {
        SCR_START     = 3'd0,
        SCR_COUNTDOWN = 3'd1,
        SCR_GAME      = 3'd2,
        SCR_PAUSE     = 3'd3,
        SCR_WIN       = 3'd4
    } screen_t;

    localparam logic [7:0] KEY_ENTER  = 8'h5A;
    localparam logic [7:0] KEY_R      = 8'h2D;
    localparam logic [7:0] KEY_P      = 8'h4D;
    localparam logic [7:0] BREAK_CODE = 8'hF0;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_press_detect.sv
// Single-cycle press pulse for one make code. A press fires only when the
// keycode pair changes, so a held key or a repeated byte never re-triggers,
// and a break sequence (F0 xx) is never taken as a press.
module key_press_detect
    import vga_pkg::*;
#(
    parameter logic [7:0] KEY = KEY_ENTER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keycode,
    output logic        press
);

    logic [15:0] r_prev;

    // Remember the keycode seen on the previous clock for change detection.
    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_prev <= 16'h0000;
        else     r_prev <= keycode;
    end

    assign press = (keycode[15:8] != BREAK_CODE) &&
                   (keycode[7:0]  == KEY)        &&
                   (keycode       != r_prev);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: picks the screen to draw, runs the frame-counted
// get-ready countdown, gates gameplay and detects the winning player.
// All outputs are registered in the same process as the state register.
module game_flow_ctrl
    import vga_pkg::*;
#(
    parameter int         N_PLAYERS    = 2,
    parameter int         SCORE_W      = 5,
    parameter int         WIN_SCORE    = 10,
    parameter int         COUNT_FRAMES = 180,
    parameter logic [7:0] KEY_START    = KEY_ENTER,
    parameter logic [7:0] KEY_RESTART  = KEY_R,
    parameter logic [7:0] KEY_PAUSE    = KEY_P
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  frame_tick,
    input  logic [N_PLAYERS*SCORE_W-1:0]          points,
    input  logic [15:0]                           keycode,
    output logic [2:0]                            screen,
    output logic [clog2_min1(N_PLAYERS)-1:0]      winner,
    output logic [$clog2(COUNT_FRAMES+1)-1:0]     countdown,
    output logic                                  game_run,
    output logic                                  score_clr
);

    localparam int WIN_W = clog2_min1(N_PLAYERS);
    localparam int CNT_W = $clog2(COUNT_FRAMES + 1);
    localparam logic [SCORE_W-1:0] WIN_THR  = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(COUNT_FRAMES);

    // Refuse to build with a threshold the score counters can never reach.
    generate
        if ((WIN_SCORE < 0) || (WIN_SCORE >= (1 << SCORE_W))) begin : g_bad_win_score
            $error("WIN_SCORE does not fit in SCORE_W bits");
        end
        if ((N_PLAYERS < 2) || (N_PLAYERS > 4)) begin : g_bad_players
            $error("N_PLAYERS must be in 2..4");
        end
    endgenerate

    logic w_press_start;
    logic w_press_restart;
    logic w_press_pause;

    key_press_detect #(.KEY(KEY_START)) u_key_start (
        .clk(clk), .rst(rst), .keycode(keycode), .press(w_press_start)
    );
    key_press_detect #(.KEY(KEY_RESTART)) u_key_restart (
        .clk(clk), .rst(rst), .keycode(keycode), .press(w_press_restart)
    );
    key_press_detect #(.KEY(KEY_PAUSE)) u_key_pause (
        .clk(clk), .rst(rst), .keycode(keycode), .press(w_press_pause)
    );

    logic             w_win_any;
    logic [WIN_W-1:0] w_win_idx;

    // Priority encoder: scanning from the top down leaves the lowest winning index.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        w_win_any = 1'b0;
        w_win_idx = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (points[i*SCORE_W +: SCORE_W] >= WIN_THR) begin
                w_win_any = 1'b1;
                w_win_idx = WIN_W'(i);
            end
        end
    end

    screen_t          r_state;
    logic [WIN_W-1:0] r_winner;
    logic [CNT_W-1:0] r_count;
    logic             r_game_run;
    logic             r_score_clr;

    // Flow FSM with countdown counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SCR_START;
            r_winner    <= '0;
            r_count     <= '0;
            r_game_run  <= 1'b0;
            r_score_clr <= 1'b0;
        end else begin
            r_score_clr <= 1'b0;
            case (r_state)
                SCR_START: begin
                    if (w_press_start) begin
                        r_state     <= SCR_COUNTDOWN;
                        r_count     <= CNT_LOAD;
                        r_score_clr <= 1'b1;
                    end
                end
                SCR_COUNTDOWN: begin
                    if (r_count == '0) begin
                        r_state    <= SCR_GAME;
                        r_game_run <= 1'b1;
                    end else if (frame_tick) begin
                        r_count <= r_count - 1'b1;
                        if (r_count == CNT_W'(1)) begin
                            r_state    <= SCR_GAME;
                            r_game_run <= 1'b1;
                        end
                    end
                end
                SCR_GAME: begin
                    // A win in the same cycle as a pause press takes priority.
                    if (w_win_any) begin
                        r_state    <= SCR_WIN;
                        r_winner   <= w_win_idx;
                        r_game_run <= 1'b0;
                    end else if (w_press_pause) begin
                        r_state    <= SCR_PAUSE;
                        r_game_run <= 1'b0;
                    end
                end
                SCR_PAUSE: begin
                    if (w_press_pause) begin
                        r_state    <= SCR_GAME;
                        r_game_run <= 1'b1;
                    end
                end
                SCR_WIN: begin
                    if (w_press_restart) begin
                        r_state     <= SCR_START;
                        r_score_clr <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= SCR_START;
                    r_count    <= '0;
                    r_game_run <= 1'b0;
                end
            endcase
        end
    end

    assign screen    = r_state;
    assign winner    = r_winner;
    assign countdown = r_count;
    assign game_run  = r_game_run;
    assign score_clr = r_score_clr;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl with four players: a vector table for the opening
// sequence, hand-written corner sequences, then randomized traffic. Every
// cycle is also compared against a rule-level model of the game flow.
module tb_game_flow_ctrl;

    localparam int NP = 4;
    localparam int SW = 5;
    localparam int WS = 10;
    localparam int CF = 180;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_tick;
    logic [NP*SW-1:0]  points;
    logic [15:0]       keycode;
    logic [2:0]        screen;
    logic [1:0]        winner;
    logic [7:0]        countdown;
    logic              game_run;
    logic              score_clr;

    always #5 clk = ~clk;

    game_flow_ctrl #(.N_PLAYERS(NP)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .points(points),
        .keycode(keycode), .screen(screen), .winner(winner),
        .countdown(countdown), .game_run(game_run), .score_clr(score_clr)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Rule-level model: mode is the screen the game should show.
    int          m_mode = 0;
    int          m_cnt  = 0;
    int          m_win  = 0;
    bit          m_clr  = 1'b0;
    logic [15:0] m_prev = 16'h0000;

    function automatic bit pressed(input logic [15:0] kc, input logic [7:0] k);
        return (kc[15:8] != 8'hF0) && (kc[7:0] == k) && (kc != m_prev);
    endfunction

    task automatic model_update();
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_win = 0; m_clr = 1'b0; m_prev = 16'h0000;
        end else begin
            bit ps, pr, pp;
            int lead;
            ps = pressed(keycode, 8'h5A);
            pr = pressed(keycode, 8'h2D);
            pp = pressed(keycode, 8'h4D);
            m_prev = keycode;
            m_clr  = 1'b0;
            case (m_mode)
                0: if (ps) begin m_mode = 1; m_cnt = CF; m_clr = 1'b1; end
                1: if (frame_tick) begin
                       m_cnt = m_cnt - 1;
                       if (m_cnt == 0) m_mode = 2;
                   end
                2: begin
                       lead = -1;
                       for (int i = 0; i < NP; i++)
                           if (lead < 0 && points[i*SW +: SW] >= WS) lead = i;
                       if (lead >= 0) begin m_mode = 4; m_win = lead; end
                       else if (pp) m_mode = 3;
                   end
                3: if (pp) m_mode = 2;
                4: if (pr) begin m_mode = 0; m_clr = 1'b1; end
                default: m_mode = 0;
            endcase
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs.
    task automatic step(input logic r, input logic t, input logic [NP*SW-1:0] p,
                        input logic [15:0] kc);
        rst = r; frame_tick = t; points = p; keycode = kc;
        @(posedge clk);
        model_update();
        #1;
        check("cycle_outputs",
              {17'd0, screen, winner, countdown, game_run, score_clr},
              {17'd0, 3'(m_mode), 2'(m_win), 8'(m_cnt), (m_mode == 2), m_clr});
    endtask

    // From START: press Enter, then tick through the whole countdown.
    task automatic go_game();
        step(1'b0, 1'b0, '0, 16'h0000);
        step(1'b0, 1'b0, '0, 16'h005A);
        for (int i = 0; i < CF; i++) step(1'b0, 1'b1, '0, 16'h005A);
        check("go_game_screen", screen, 3'd2);
    endtask

    typedef struct {
        logic        r;
        logic        t;
        logic [15:0] kc;
        logic [2:0]  scr;
        logic        clr;
        logic        run;
        logic [7:0]  cd;
    } vec_t;

    vec_t vecs [8];
    logic [15:0] codes [7] = '{16'h005A, 16'h002D, 16'h004D, 16'hF04D,
                               16'hF05A, 16'h0000, 16'h0012};

    initial begin
        int transitions;
        logic [2:0] prev_scr;
        logic [15:0] kc;
        logic [NP*SW-1:0] p;
        logic r, t;

        vecs[0] = '{1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 1'b0, 16'hF05A, 3'd0, 1'b0, 1'b0, 8'd0};
        vecs[3] = '{1'b0, 1'b1, 16'h005A, 3'd1, 1'b1, 1'b0, 8'd180};
        vecs[4] = '{1'b0, 1'b0, 16'h005A, 3'd1, 1'b0, 1'b0, 8'd180};
        vecs[5] = '{1'b0, 1'b1, 16'h005A, 3'd1, 1'b0, 1'b0, 8'd179};
        vecs[6] = '{1'b0, 1'b0, 16'h004D, 3'd1, 1'b0, 1'b0, 8'd179};
        vecs[7] = '{1'b0, 1'b1, 16'h004D, 3'd1, 1'b0, 1'b0, 8'd178};

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].r, vecs[i].t, '0, vecs[i].kc);
            check($sformatf("vec%0d_screen", i), screen, vecs[i].scr);
            check($sformatf("vec%0d_clr", i), score_clr, vecs[i].clr);
            check($sformatf("vec%0d_run", i), game_run, vecs[i].run);
            check($sformatf("vec%0d_cd", i), countdown, vecs[i].cd);
        end

        // Finish the countdown: 177 more ticks leave 1, the last enters GAME.
        for (int i = 0; i < 177; i++) step(1'b0, 1'b1, '0, 16'h004D);
        check("cd_last_frame", countdown, 8'd1);
        check("cd_still_counting", screen, 3'd1);
        step(1'b0, 1'b1, '0, 16'h004D);
        check("game_entered", screen, 3'd2);
        check("game_run_high", game_run, 1'b1);
        check("game_cd_zero", countdown, 8'd0);

        // Player 1 reaches the winning score.
        p = {5'd0, 5'd0, 5'd10, 5'd3};
        step(1'b0, 1'b0, p, 16'h004D);
        check("win_screen", screen, 3'd4);
        check("win_player1", winner, 2'd1);
        check("win_run_low", game_run, 1'b0);
        step(1'b0, 1'b0, p, 16'h002D);
        check("restart_screen", screen, 3'd0);
        check("restart_clr", score_clr, 1'b1);
        step(1'b0, 1'b0, '0, 16'h002D);
        check("restart_clr_once", score_clr, 1'b0);

        // Players 1 and 3 tie: the lower index wins.
        go_game();
        p = {5'd10, 5'd0, 5'd10, 5'd0};
        step(1'b0, 1'b0, p, 16'h005A);
        check("tie_screen", screen, 3'd4);
        check("tie_winner", winner, 2'd1);
        step(1'b0, 1'b0, '0, 16'h002D);
        check("tie_winner_holds", winner, 2'd1);

        // Held pause key toggles exactly once; break code does nothing.
        go_game();
        transitions = 0;
        for (int i = 0; i < 50; i++) begin
            prev_scr = screen;
            step(1'b0, 1'b0, '0, 16'h004D);
            if (screen != prev_scr) transitions++;
        end
        check("pause_once", transitions, 1);
        check("pause_screen", screen, 3'd3);
        step(1'b0, 1'b0, {5'd12, 5'd12, 5'd12, 5'd12}, 16'hF04D);
        check("pause_break_ignored", screen, 3'd3);
        step(1'b0, 1'b0, '0, 16'h004D);
        check("unpause_screen", screen, 3'd2);

        // Pause press and win in the same cycle: win has priority.
        step(1'b0, 1'b0, '0, 16'h0000);
        step(1'b0, 1'b0, {5'd0, 5'd0, 5'd0, 5'd10}, 16'h004D);
        check("win_over_pause", screen, 3'd4);
        check("win_over_pause_idx", winner, 2'd0);
        step(1'b0, 1'b0, '0, 16'h002D);
        check("back_to_start", screen, 3'd0);

        // Reset in the middle of the countdown.
        step(1'b0, 1'b0, '0, 16'h0000);
        step(1'b0, 1'b0, '0, 16'h005A);
        for (int i = 0; i < 83; i++) step(1'b0, 1'b1, '0, 16'h005A);
        check("mid_cd_97", countdown, 8'd97);
        step(1'b1, 1'b1, '0, 16'hF05A);
        check("rst_screen", screen, 3'd0);
        check("rst_cd", countdown, 8'd0);
        check("rst_no_clr", score_clr, 1'b0);
        step(1'b0, 1'b0, '0, 16'hF05A);
        check("break_enter_start", screen, 3'd0);
        check("break_enter_no_clr", score_clr, 1'b0);

        // Randomized traffic against the model.
        kc = 16'h0000;
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 7) == 0) kc = codes[$urandom_range(0, 6)];
            t = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < NP; i++)
                p[i*SW +: SW] = ($urandom_range(0, 59) == 0) ?
                                SW'($urandom_range(10, 31)) : SW'($urandom_range(0, 9));
            step(r, t, p, kc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised game-flow controller that selects which screen the VGA pipeline draws and gates gameplay. It supports N players, a configurable winning score, a frame-counted "get ready" countdown, a pause mode, and edge-detected keyboard commands. It sits between the PS/2 keyboard decoder and score counters (inputs) and the screen mux, ball/paddle logic and score-clear logic (outputs).

## Interface
Parameters:
- N_PLAYERS, default 2: number of score inputs (2..4).
- SCORE_W, default 5: width of each score.
- WIN_SCORE, default 10: score at or above which a player wins.
- COUNT_FRAMES, default 180: frame ticks spent in COUNTDOWN.
- KEY_START, default 8'h5A: make code (Enter) that starts a match.
- KEY_RESTART, default 8'h2D: make code (R) that returns from WIN to START.
- KEY_PAUSE, default 8'h4D: make code (P) that toggles pause.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- frame_tick, in, 1: one-cycle pulse per video frame.
- points, in, N_PLAYERS*SCORE_W: packed scores; player i at [i*SCORE_W +: SCORE_W].
- keycode, in, 16: {previous byte, last byte} from the PS/2 decoder.
- screen, out, 3: registered screen_t code.
- winner, out, $clog2(N_PLAYERS) (min 1): registered winning player index.
- countdown, out, $clog2(COUNT_FRAMES+1): registered frames remaining in COUNTDOWN, otherwise 0.
- game_run, out, 1: high only in GAME; enables ball/paddle motion.
- score_clr, out, 1: one-cycle pulse that clears score counters.

## Operation
- Key press: press(K) is a one-cycle pulse when keycode[15:8] != 8'hF0, keycode[7:0] == K, and keycode differs from its value on the previous clock. A held key or an unchanged keycode never re-fires.
- States:
  - START → COUNTDOWN on press(KEY_START). score_clr pulses on that transition.
  - COUNTDOWN: the counter loads COUNT_FRAMES on entry and decrements on each frame_tick. When it reaches 0, the FSM moves to GAME. press(KEY_PAUSE) is ignored in this state.
  - GAME → WIN when any score >= WIN_SCORE. winner is set to the lowest such index, so ties go to the lower index.
  - GAME → PAUSE on press(KEY_PAUSE), only if no win condition holds in the same cycle. Win has priority.
  - PAUSE → GAME on press(KEY_PAUSE). Score inputs are ignored while paused.
  - WIN → START on press(KEY_RESTART). score_clr pulses on that transition.
  - Illegal state → START.
- Screen encoding (screen_t): START=3'd0, COUNTDOWN=3'd1, GAME=3'd2, PAUSE=3'd3, WIN=3'd4.
- winner holds its value outside WIN and is only updated on the GAME→WIN transition.
- Score comparison is unsigned, SCORE_W bits wide. WIN_SCORE must fit in SCORE_W bits; this is elaboration-checked.

## Timing
- Reset values: state=START, screen=0, winner=0, countdown=0, game_run=0, score_clr=0, and the keycode history register equals 16'h0000.
- All outputs are registered from next-state decode, so screen changes on the same edge as the state register. There is zero added latency relative to the state.
- Key press to state change: the keycode changes in cycle n, and the state and screen update at edge n+1.
- Countdown: with COUNT_FRAMES=F, GAME is entered on the edge following the F-th frame_tick after entry. A frame_tick on the entry edge itself is not counted.
- score_clr is high for exactly the one cycle after the transition edge.
- rst asserted mid-operation (any state): the next edge forces the reset values, and no score_clr pulse is issued.
- A simultaneous press(KEY_PAUSE) and win in GAME resolves to WIN.

## Structure
- vga_pkg gets the following additions:
  - typedef enum logic [2:0] screen_t.
  - Key-code constants KEY_ENTER, KEY_R, KEY_P and BREAK_CODE=8'hF0, used as parameter defaults.
- Sub-module key_press_detect (parameter KEY; clk, rst, keycode in, press out) is instantiated three times.
- The FSM, countdown counter and winner priority encoder live in game_flow_ctrl.

## Test plan
- Reset, then keycode=16'h005A → COUNTDOWN (screen=1) and score_clr pulses for 1 cycle. Then 180 frame_ticks → screen=2, game_run=1.
- In GAME, set points={5'd10,5'd3} (player1=10) → screen=4, winner=1, game_run=0. Then keycode=16'h002D → screen=0 and score_clr pulses.
- N_PLAYERS=4 with players 1 and 3 reaching WIN_SCORE in the same cycle → winner=1.
- In GAME, keycode=16'h004D held for 50 cycles → exactly one transition to PAUSE (screen=3). Next, keycode=16'hF04D causes no change, then 16'h004D → back to GAME.
- In GAME, press(KEY_PAUSE) in the same cycle as points reaching 10 → WIN, not PAUSE.
- rst asserted mid-COUNTDOWN with countdown=97 → next edge gives screen=0, countdown=0, no score_clr. keycode=16'hF05A in START → stays in START.
